big_field_insert_tx: RTL

Transmit-side counterpart to the big-field parser. Latches a DSIZE*FIELD_LEN-bit field value, emits it as FIELD_LEN header beats at the start of an outgoing AXI-stream frame, then passes the payload frame through unchanged up to and including its tlast beat. Sits in front of the UDP transmit path, so the receive-side parser at the far end recovers the field from the first FIELD_LEN beats.

---
 rtl/big_field_insert_tx_if.sv | 28 ++
 rtl/big_field_insert_tx.sv | 114 +++++++++++
 2 files changed

// File: rtl/big_field_insert_tx_if.sv
// Handshake bundle for big_field_insert_tx: field value port plus payload-in and frame-out AXI-stream.
interface big_field_insert_tx_if #(
    parameter int unsigned DSIZE     = 8,
    parameter int unsigned FIELD_LEN = 8
) ();
    logic                         enable;
    logic [DSIZE*FIELD_LEN-1:0]   value;
    logic                         value_valid;
    logic                         value_ready;
    logic [DSIZE-1:0]             s_tdata;
    logic                         s_tvalid;
    logic                         s_tlast;
    logic                         s_tready;
    logic [DSIZE-1:0]             m_tdata;
    logic                         m_tvalid;
    logic                         m_tlast;
    logic                         m_tready;

    modport master (
        output enable, value, value_valid, s_tdata, s_tvalid, s_tlast, m_tready,
        input  value_ready, s_tready, m_tdata, m_tvalid, m_tlast
    );

    modport slave (
        input  enable, value, value_valid, s_tdata, s_tvalid, s_tlast, m_tready,
        output value_ready, s_tready, m_tdata, m_tvalid, m_tlast
    );
endinterface

// File: rtl/big_field_insert_tx.sv
// Prepends a latched DSIZE*FIELD_LEN-bit field as FIELD_LEN MSB-first header beats, then
// passes the payload frame through unchanged up to its tlast.
module big_field_insert_tx #(
    parameter int unsigned DSIZE     = 8,
    parameter int unsigned FIELD_LEN = 8
) (
    input  logic                  i_clock,
    input  logic                  i_rst,
    big_field_insert_tx_if.slave  bus,
    output logic [15:0]           o_frame_cnt
);
    localparam int unsigned FW     = DSIZE * FIELD_LEN;
    localparam int unsigned BEAT_W = (FIELD_LEN > 1) ? $clog2(FIELD_LEN) : 1;
    localparam logic [BEAT_W-1:0] LAST_BEAT = BEAT_W'(FIELD_LEN - 1);

    typedef enum logic [1:0] {ST_IDLE, ST_HEAD, ST_BODY} state_t;

    state_t              r_state;
    state_t              w_state_next;
    logic [FW-1:0]       r_value;
    logic [BEAT_W-1:0]   r_beat;
    logic [15:0]         r_frame_cnt;
    logic                w_value_fire;
    logic                w_head_fire;
    logic                w_last_fire;

    assign w_value_fire = (r_state == ST_IDLE) && bus.enable && bus.value_valid;
    assign w_head_fire  = (r_state == ST_HEAD) && bus.m_tready;
    assign w_last_fire  = (r_state == ST_BODY) && bus.s_tvalid && bus.m_tready && bus.s_tlast;

    always_ff @(posedge i_clock) begin
        if (i_rst) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            ST_IDLE: begin
                if (w_value_fire) begin
                    w_state_next = ST_HEAD;
                end else if (!bus.enable && bus.s_tvalid) begin
                    w_state_next = ST_BODY;
                end
            end
            ST_HEAD: begin
                if (w_head_fire && (r_beat == LAST_BEAT)) begin
                    w_state_next = ST_BODY;
                end
            end
            ST_BODY: begin
                if (w_last_fire) begin
                    w_state_next = ST_IDLE;
                end
            end
            default: w_state_next = ST_IDLE;
        endcase
    end

    // Header data is always the top slice of the shifting field register.
    always_comb begin
        bus.value_ready = 1'b0;
        bus.s_tready    = 1'b0;
        bus.m_tvalid    = 1'b0;
        bus.m_tlast     = 1'b0;
        bus.m_tdata     = '0;
        case (r_state)
            ST_IDLE: begin
                bus.value_ready = bus.enable;
            end
            ST_HEAD: begin
                bus.m_tvalid = 1'b1;
                bus.m_tdata  = r_value[FW-1 -: DSIZE];
            end
            ST_BODY: begin
                bus.m_tdata  = bus.s_tdata;
                bus.m_tvalid = bus.s_tvalid;
                bus.m_tlast  = bus.s_tlast;
                bus.s_tready = bus.m_tready;
            end
            default: ;
        endcase
        if (i_rst) begin
            bus.value_ready = 1'b0;
            bus.s_tready    = 1'b0;
            bus.m_tvalid    = 1'b0;
            bus.m_tlast     = 1'b0;
        end
    end

    always_ff @(posedge i_clock) begin
        if (i_rst) begin
            r_value     <= '0;
            r_beat      <= '0;
            r_frame_cnt <= '0;
        end else begin
            if (w_value_fire) begin
                r_value <= bus.value;
                r_beat  <= '0;
            end else if (w_head_fire) begin
                r_value <= r_value << DSIZE;
                r_beat  <= r_beat + BEAT_W'(1);
            end
            if (w_last_fire) begin
                r_frame_cnt <= r_frame_cnt + 16'd1;
            end
        end
    end

    assign o_frame_cnt = r_frame_cnt;
endmodule
